// File: rtl/i2c_slave_if.sv
// i2c_slave_if -- user-side byte handshake of the I2C target.
//
// Signals:
//   rx_data  [7:0]  last byte written by the bus master
//   rx_valid        one-cycle strobe, rx_data valid in that cycle
//   tx_data  [7:0]  next byte to return on a read (show-ahead)
//   tx_req          one-cycle strobe, tx_data consumed in that cycle
//   busy            addressed transaction in progress
//   rw              R/W bit of the current transaction (1 = read)
//
// Modports: slave = the I2C target block, master = the user logic around it.
interface i2c_slave_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       rw;

  modport slave (
    output rx_data, rx_valid, tx_req, busy, rw,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, busy, rw,
    output tx_data
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave -- I2C target with a fixed 7-bit address.
//
// SCL and SDA are synchronized and glitch-filtered on clk, then START/STOP
// and SCL edges drive a byte-level state machine. Write bytes are delivered
// on host.rx_valid, read bytes are fetched with host.tx_req. SDA is driven
// open-drain (0 or Z). No clock stretching.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   scl   I2C clock input (externally pulled up)
//   sda   I2C data, open-drain
//   host  i2c_slave_if.slave byte handshake (rx_data/rx_valid, tx_data/tx_req,
//         busy, rw)
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  i2c_slave_if.slave  host
);

  localparam logic [3:0] FILT_TOP = 4'(FILT_LEN - 1);

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0] line_raw;
  logic [1:0] filt;
  logic [1:0] rise;
  logic [1:0] fall;

  assign line_raw = {sda, scl};

  // Each line: 2-flop synchronizer, then the filtered level only follows the
  // synchronized level after FILT_LEN consecutive differing samples. Edge
  // strobes are asserted in the first cycle the filtered level is new.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       sync1_q;
      logic       sync2_q;
      logic       filt_q;
      logic       rise_q;
      logic       fall_q;
      logic [3:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          filt_q  <= 1'b1;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= line_raw[gi];
          sync2_q <= sync1_q;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          if (sync2_q == filt_q) begin
            cnt_q <= '0;
          end else if (cnt_q == FILT_TOP) begin
            filt_q <= sync2_q;
            rise_q <= sync2_q;
            fall_q <= ~sync2_q;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
      end

      assign filt[gi] = filt_q;
      assign rise[gi] = rise_q;
      assign fall[gi] = fall_q;
    end
  endgenerate

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_rise  = rise[0];
  assign scl_fall  = fall[0];
  assign start_det = fall[1] & scl_f;
  assign stop_det  = rise[1] & scl_f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] rx_data_q;
  logic       sda_low_q;
  logic       rx_valid_q;
  logic       tx_req_q;
  logic       busy_q;
  logic       rw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_low_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start_det) begin
        // Covers repeated START as well: a new address phase always begins.
        sda_low_q <= 1'b0;
        bit_cnt_q <= '0;
        busy_q    <= 1'b0;
        state_q   <= S_ADDR;
      end else if (stop_det) begin
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
        state_q   <= S_IDLE;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                // shift_q[6:0] holds the 7 address bits before this shift.
                if (shift_q[6:0] == SLAVE_ADDR && shift_q[6:0] != 7'd0) begin
                  rw_q   <= sda_f;
                  busy_q <= 1'b1;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              sda_low_q <= 1'b1;
              state_q   <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                tx_req_q  <= 1'b1;
                sda_low_q <= ~host.tx_data[7];
                shift_q   <= {host.tx_data[6:0], 1'b0};
                bit_cnt_q <= 4'd1;
                state_q   <= S_RD_DATA;
              end else begin
                sda_low_q <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              sda_low_q  <= 1'b1;
              bit_cnt_q  <= '0;
              state_q    <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_low_q <= 1'b0;
              state_q   <= S_WR_DATA;
            end
          end
          S_RD_DATA: begin
            // bit_cnt_q counts bits already put on the bus; bit 7 went out
            // when the byte was loaded.
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_low_q <= 1'b0;
                state_q   <= S_RD_ACK;
              end else begin
                sda_low_q <= ~shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise && sda_f) begin
              busy_q  <= 1'b0;
              state_q <= S_IGNORE;
            end else if (scl_fall) begin
              // Only reachable after the master ACKed on the preceding rise.
              tx_req_q  <= 1'b1;
              sda_low_q <= ~host.tx_data[7];
              shift_q   <= {host.tx_data[6:0], 1'b0};
              bit_cnt_q <= 4'd1;
              state_q   <= S_RD_DATA;
            end
          end
          default: begin
            sda_low_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda           = sda_low_q ? 1'b0 : 1'bz;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
  assign host.tx_req   = tx_req_q;
  assign host.busy     = busy_q;
  assign host.rw       = rw_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Testbench for i2c_slave: a bit-banged I2C master drives the bus, a
// reference model predicts ACKs, read bytes and the rx/tx strobes, and a
// monitor scores the strobes against expectation queues.
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h50;
  localparam int         FLT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m_low = 1'b0;
  wire  sda;

  assign sda = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_if host ();

  i2c_slave #(.SLAVE_ADDR(ADDR), .FILT_LEN(FLT)) dut (
    .clk  (clk),
    .rst  (rst),
    .scl  (scl),
    .sda  (sda),
    .host (host)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int q_cyc = 15;
  int sda_hi_changes = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] tx_supply[$];
  logic [7:0] wbuf[4];
  logic [7:0] rbuf[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic bus_bit();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  // Reference model: the target answers only its own non-zero address.
  function automatic logic addr_hit(input logic [7:0] ab);
    return (ab[7:1] == ADDR) && (ab[7:1] != 7'd0);
  endfunction

  // Scoreboard monitor and tx_data provider.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (!rst) begin
      if (host.rx_valid) begin
        chk("rx_expected", 32'(exp_rx.size() > 0), 1);
        if (exp_rx.size() > 0) begin
          e = exp_rx.pop_front();
          chk("rx_data", host.rx_data, e);
          $display("rx_valid data=0x%02h expected=0x%02h", host.rx_data, e);
        end
      end
      if (host.tx_req) begin
        chk("tx_req_not_with_rx", host.rx_valid, 0);
        chk("tx_req_expected", 32'(tx_supply.size() > 0), 1);
        if (tx_supply.size() > 0) begin
          e = tx_supply.pop_front();
          $display("tx_req consumed=0x%02h", e);
        end
      end
    end
    host.tx_data = (tx_supply.size() > 0) ? tx_supply[0] : 8'h00;
  end

  // Watch for the target changing its SDA drive while SCL is high.
  logic dl_prev = 1'b0, scl_prev = 1'b1, rst_prev = 1'b1;
  always @(negedge clk) begin : stab
    logic dl;
    dl = (sda === 1'b0) && !sda_m_low;
    if (scl && scl_prev && !rst && !rst_prev && dl != dl_prev) sda_hi_changes++;
    dl_prev  = dl;
    scl_prev = scl;
    rst_prev = rst;
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // glitch: 0 none, 1 = 2-cycle SCL low pulse, 2 = 2-cycle SDA release.
  task automatic clock_bit(input logic b, output logic s, input int glitch);
    sda_m_low = ~b;
    wcyc(q_cyc);
    scl = 1'b1;
    if (glitch == 1) begin
      wcyc(q_cyc / 2); scl = 1'b0; wcyc(2); scl = 1'b1; wcyc(q_cyc / 2);
    end else if (glitch == 2) begin
      wcyc(q_cyc / 2); sda_m_low = 1'b0; wcyc(2); sda_m_low = ~b; wcyc(q_cyc / 2);
    end else begin
      wcyc(q_cyc);
    end
    s = bus_bit();
    wcyc(q_cyc);
    scl = 1'b0;
    wcyc(q_cyc);
  endtask

  task automatic m_start();
    sda_m_low = 1'b0; wcyc(q_cyc);
    scl = 1'b1;       wcyc(q_cyc);
    sda_m_low = 1'b1; wcyc(q_cyc);
    scl = 1'b0;       wcyc(q_cyc);
  endtask

  task automatic m_stop();
    sda_m_low = 1'b1; wcyc(q_cyc);
    scl = 1'b1;       wcyc(q_cyc);
    sda_m_low = 1'b0; wcyc(q_cyc);
  endtask

  task automatic m_write_byte(input logic [7:0] b, input logic exp_ack, input string name,
                              input int gpos, input int gkind);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s, ((7 - i) == gpos) ? gkind : 0);
    clock_bit(1'b1, s, 0);
    chk({name, "_ack"}, s, exp_ack);
  endtask

  task automatic m_read_byte(input logic [7:0] exp, input logic mack, input string name);
    logic s;
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s, 0);
      d = {d[6:0], s};
    end
    chk(name, d, exp);
    clock_bit(mack, s, 0);
  endtask

  task automatic addr_phase(input logic [7:0] ab);
    m_start();
    m_write_byte(ab, addr_hit(ab) ? 1'b0 : 1'b1, "addr", -1, 0);
    chk("busy_after_addr", host.busy, addr_hit(ab));
    if (addr_hit(ab)) chk("rw_after_addr", host.rw, ab[0]);
  endtask

  task automatic wr_phase(input logic [7:0] ab, input int n, input int gpos, input int gkind);
    logic hit;
    hit = addr_hit(ab) && !ab[0];
    $display("write addr=0x%02h bytes=%0d hit=%0b glitch=%0d", ab, n, hit, gkind);
    addr_phase(ab);
    for (int i = 0; i < n; i++) begin
      if (hit) exp_rx.push_back(wbuf[i]);
      m_write_byte(wbuf[i], hit ? 1'b0 : 1'b1, "wr_data", (i == 0) ? gpos : -1, gkind);
    end
  endtask

  task automatic rd_phase(input logic [7:0] ab, input int n);
    logic hit;
    hit = addr_hit(ab) && ab[0];
    $display("read addr=0x%02h bytes=%0d hit=%0b", ab, n, hit);
    if (hit) for (int i = 0; i < n; i++) tx_supply.push_back(rbuf[i]);
    addr_phase(ab);
    for (int i = 0; i < n; i++)
      m_read_byte(hit ? rbuf[i] : 8'hFF, (i == n - 1) ? 1'b1 : 1'b0, "rd_data");
    chk("busy_after_nack", host.busy, 0);
    chk("sda_released_after_nack", bus_bit(), 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    logic s;
    logic [4:0] tail;
    logic [7:0] ab;
    int n;

    // Reset state
    wcyc(5);
    chk("rst_rx_data", host.rx_data, 0);
    chk("rst_rx_valid", host.rx_valid, 0);
    chk("rst_tx_req", host.tx_req, 0);
    chk("rst_busy", host.busy, 0);
    chk("rst_rw", host.rw, 0);
    chk("rst_sda", bus_bit(), 1);
    rst = 1'b0;
    wcyc(10);

    // Write at SCL = clk/500
    q_cyc = 125;
    wbuf[0] = 8'h3C; wbuf[1] = 8'hA5;
    wr_phase(8'hA0, 2, -1, 0);
    m_stop();
    wcyc(10);
    chk("busy_after_stop", host.busy, 0);
    q_cyc = 15;

    // Address mismatch
    wbuf[0] = 8'h11;
    wr_phase(8'hA2, 1, -1, 0);
    m_stop();
    chk("busy_mismatch", host.busy, 0);

    // Read, ACK then NACK
    rbuf[0] = 8'h96; rbuf[1] = 8'h5A;
    rd_phase(8'hA1, 2);
    m_stop();

    // Repeated START from write into read
    wbuf[0] = 8'h07;
    wr_phase(8'hA0, 1, -1, 0);
    rbuf[0] = 8'($urandom);
    rd_phase(8'hA1, 1);
    m_stop();

    // STOP after 4 data bits, then a byte with no START must be ignored
    $display("abort after 4 bits");
    addr_phase(8'hA0);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s, 0);
    m_stop();
    wcyc(10);
    chk("busy_after_abort", host.busy, 0);
    m_write_byte(8'hA0, 1'b1, "idle_no_start", -1, 0);
    m_stop();

    // Filter: 2-cycle SCL low glitch, then 2-cycle SDA high glitch
    wbuf[0] = 8'($urandom);
    wr_phase(8'hA0, 1, 2, 1);
    m_stop();
    wbuf[0] = 8'($urandom) & 8'hEF;
    wr_phase(8'hA0, 1, 3, 2);
    m_stop();

    // Reset during the third bit of a 0x96 read
    $display("reset during read of 0x96");
    rbuf[0] = 8'h96;
    tx_supply.push_back(8'h96);
    addr_phase(8'hA1);
    clock_bit(1'b1, s, 0); chk("rst_rd_bit7", s, 1);
    clock_bit(1'b1, s, 0); chk("rst_rd_bit6", s, 0);
    sda_m_low = 1'b0; wcyc(q_cyc);
    scl = 1'b1; wcyc(q_cyc / 2);
    chk("rst_rd_bit5_low", bus_bit(), 0);
    rst = 1'b1;
    wcyc(1);
    chk("rst_sda_release", bus_bit(), 1);
    chk("rst_busy", host.busy, 0);
    wcyc(3);
    rst = 1'b0;
    wcyc(q_cyc);
    scl = 1'b0; wcyc(q_cyc);
    tail = 5'h00;
    for (int i = 0; i < 5; i++) begin
      clock_bit(1'b1, s, 0);
      tail = {tail[3:0], s};
    end
    chk("rst_rest_released", tail, 5'h1F);
    clock_bit(1'b0, s, 0);
    m_write_byte(8'hA0, 1'b1, "post_rst_no_start", -1, 0);
    wbuf[0] = 8'($urandom);
    wr_phase(8'hA0, 1, -1, 0);
    m_stop();

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      ab[7:1] = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom);
      ab[0]   = 1'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = 8'($urandom);
        rbuf[i] = 8'($urandom);
      end
      if (ab[0]) rd_phase(ab, n);
      else wr_phase(ab, n, -1, 0);
      m_stop();
      wcyc(10);
      chk("busy_after_rand_stop", host.busy, 0);
    end

    wcyc(50);
    chk("rx_pending", exp_rx.size(), 0);
    chk("tx_pending", tx_supply.size(), 0);
    chk("sda_stable_scl_high", sda_hi_changes, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the other end of the bus driven by our I2C master block.
- Oversamples SCL/SDA on the system clock and detects START, STOP and repeated START.
- Matches a fixed 7-bit address and ACKs it. Delivers write bytes on a valid strobe and fetches read bytes through a request strobe.
- SDA is driven open-drain (0 or Z only). SCL is input-only; clock stretching is not supported.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this block responds to.
- FILT_LEN, 3, number of consecutive equal synchronized samples required before the filtered SCL/SDA changes. Range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock, externally pulled up.
- sda  inout  1  I2C data. Block drives only 1'b0 or Z.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_data  input  8  next byte to return to the master. Sampled in the cycle tx_req=1 (show-ahead).
- tx_req  output  1  one-cycle pulse; block consumes tx_data this cycle.
- busy  output  1  high from address match until STOP, START or NACK-terminated read.
- rw  output  1  R/W bit of the current transaction (1 = read). Valid while busy=1.

Behaviour:
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer, then a FILT_LEN consecutive-sample filter, giving sclf and sdaf.
  - Filtered values reset to 1.
  - Edge strobes are registered from sclf/sdaf.
  - Total input latency is 2+FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are ignored.
- Bus conditions:
  - START = sdaf falls while sclf=1. STOP = sdaf rises while sclf=1.
  - Both are honoured in every state, including mid-byte and mid-ACK.
  - START: release SDA, clear bit counter, go to ADDR.
  - STOP: release SDA, go to IDLE, busy=0.
- Bit timing:
  - Received bits are sampled on the sclf rising edge, MSB first.
  - Any change to the SDA drive happens only in the cycle after a sclf falling edge is detected. SDA never changes while SCL is high.
- States:
  - IDLE: SDA released. Wait for START.
  - ADDR: shift 8 bits. At the 8th rising edge compare bits[7:1] with SLAVE_ADDR.
    - Match: latch rw=bit0, busy=1, then on the next falling edge drive SDA=0 and go to ADDR_ACK.
    - Mismatch, including general-call address 0: go to IGNORE.
  - ADDR_ACK: on the falling edge that ends the ACK clock:
    - rw=0: release SDA, go to WR_DATA.
    - rw=1: pulse tx_req, load the shift register from tx_data, drive bit7, go to RD_DATA.
  - WR_DATA: shift 8 bits. At the 8th falling edge, rx_data=byte, rx_valid=1 for one cycle, drive ACK (SDA=0), go to WR_ACK. Every write byte is ACKed.
  - WR_ACK: release SDA at the next falling edge, go to WR_DATA.
  - RD_DATA: drive the next bit on each falling edge (SDA=0 if bit=0, else Z). After the 8th bit's falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit on the rising edge.
    - ACK (0): at the next falling edge pulse tx_req, load tx_data, drive bit7, go to RD_DATA.
    - NACK (1): busy=0, go to IGNORE.
  - IGNORE: SDA released. Wait for START or STOP.
- Reset values: rx_data=0, rx_valid=0, tx_req=0, busy=0, rw=0, SDA released (Z), state=IDLE, bit counter=0.
- rst asserted mid-transaction releases SDA on the next clk edge. The block then ignores the bus until a fresh START.
- rx_valid and tx_req are never asserted in the same cycle.
- tx_req is never asserted for a write transaction.

Test Plan:
- Write: START, 0xA0, 0x3C, 0xA5, STOP (SCL = clk/500) -> SDA low during all 3 ACK clocks; rx_valid pulses twice with 0x3C then 0xA5; busy 1→0 at STOP.
- Address mismatch: START, 0xA2, 0x11, STOP -> SDA never driven low by the block; rx_valid stays 0; busy stays 0.
- Read: START, 0xA1; tx_data=0x96 then 0x5A; master ACKs byte 1 and NACKs byte 2; STOP -> bus carries 0x96, 0x5A; tx_req pulses exactly twice; SDA released after the NACK.
- Repeated START: write 0xA0, 0x07, then repeated START, 0xA1, read 1 byte -> rx_valid once (0x07), rw changes to 1, tx_req once, no STOP required between phases.
- Abort and glitches: STOP after 4 data bits -> no rx_valid, state IDLE. A 2-cycle SCL low glitch with FILT_LEN=3 -> no bit counted.
- Reset mid-read: rst=1 during bit 3 of 0x96 -> SDA released next cycle; busy=0; following bus traffic ignored until a new START, then 0xA0 is ACKed normally.
